apb_rr_arbiter: RTL and testbench

Shares one APB completer port (e.g. the APB-to-simple-memory bridge) between NUM_REQ APB requesters.
Arbitration is round-robin and one transfer is outstanding at a time.
The block regenerates clean SETUP/ACCESS phases toward the completer, stalls the non-granted requesters with pready=0, and enforces an access timeout.
It sits between the interconnect/masters and the single APB slave bridge.

---
 rtl/base_pkg.sv | 31 +++
 rtl/apb_rr_arbiter_rr_pick.sv | 36 +++
 rtl/apb_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/base_pkg.sv
// Shared APB types and arbiter definitions used by the APB fabric blocks.
package base_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_SW = APB_DW / 8;

    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

    typedef struct packed {
        logic              psel;
        logic              penable;
        logic              pwrite;
        logic [APB_AW-1:0] paddr;
        logic [APB_DW-1:0] pwdata;
        logic [APB_SW-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic              pready;
        logic [APB_DW-1:0] prdata;
        logic              pslverr;
    } apb_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } arb_state_e;

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    input  logic [NUM_REQ-1:0]         excl_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] elig;
    logic [IDX_W:0]     pos;

    assign elig    = req_i & ~excl_i;
    assign valid_o = |elig;

    // Scan from the farthest offset down so the nearest eligible request wins last.
    always_comb begin
        gnt_o = '0;
        pos   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                pos = pos - (IDX_W + 1)'(NUM_REQ);
            end
            if (elig[pos[IDX_W-1:0]]) begin
                gnt_o                 = '0;
                gnt_o[pos[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB completer between NUM_REQ requesters,
// one transfer at a time, with clean SETUP/ACCESS regeneration and an ACCESS timeout.
module apb_rr_arbiter
    import base_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  apb_req_t  [NUM_REQ-1:0] req_i,
    output apb_resp_t [NUM_REQ-1:0] resp_o,
    output apb_req_t                req_o,
    input  apb_resp_t               resp_i,
    output logic      [NUM_REQ-1:0] gnt_o,
    output logic                    timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e state_q, state_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] psel_vec;
    logic [NUM_REQ-1:0] g_onehot;
    logic [NUM_REQ-1:0] pick_excl;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   g_inc;
    logic               pick_vld;
    logic               in_access;
    logic               timeout_hit;
    logic               done;

    always_comb begin
        psel_vec = '0;
        g_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            psel_vec[k] = req_i[k].psel;
        end
        g_onehot[g_q] = 1'b1;
    end

    assign g_inc       = (g_q == IDX_LAST) ? '0 : g_q + 1'b1;
    assign in_access   = (state_q == ACCESS);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_access && !resp_i.pready && (cnt_q == CNT_LAST);
    assign done        = in_access && (resp_i.pready || timeout_hit);

    // On a completing edge the finishing owner's psel is stale, so it is masked out
    // and the search starts just past it, which is where the pointer is heading anyway.
    assign pick_ptr  = in_access ? g_inc : rr_q;
    assign pick_excl = in_access ? g_onehot : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (psel_vec),
        .ptr_i   (pick_ptr),
        .excl_i  (pick_excl),
        .gnt_o   (pick_gnt),
        .valid_o (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_gnt[k]) begin
                pick_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    g_d     = pick_idx;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (done) begin
                    rr_d  = g_inc;
                    cnt_d = '0;
                    if (pick_vld) begin
                        g_d     = pick_idx;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_o     = '0;
        resp_o    = '0;
        gnt_o     = '0;
        timeout_o = 1'b0;
        if (state_q != IDLE) begin
            gnt_o         = g_onehot;
            req_o         = req_i[g_q];
            req_o.psel    = 1'b1;
            req_o.penable = in_access;
        end
        if (in_access) begin
            if (timeout_hit) begin
                resp_o[g_q].pready  = 1'b1;
                resp_o[g_q].pslverr = 1'b1;
                timeout_o           = 1'b1;
            end else begin
                resp_o[g_q] = resp_i;
            end
            // An owner that abandoned its transfer gets nothing back.
            if (!req_i[g_q].psel) begin
                resp_o[g_q] = '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: directed scenarios plus random traffic against a cycle reference model.
module tb_apb_rr_arbiter;
    import base_pkg::*;

    localparam int N = 3;
    localparam int T = 4;

    logic               clk_i = 1'b0;
    logic               rst_i;
    apb_req_t  [N-1:0]  req_i;
    apb_resp_t [N-1:0]  resp_o;
    apb_req_t           req_o;
    apb_resp_t          resp_i;
    logic      [N-1:0]  gnt_o;
    logic               timeout_o;

    apb_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .resp_o    (resp_o),
        .req_o     (req_o),
        .resp_i    (resp_i),
        .gnt_o     (gnt_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: owner (-1 when free), whether in the setup beat, access beats so far, rr pointer.
    int        m_owner = -1;
    bit        m_setup = 1'b0;
    int        m_acc   = 0;
    int        m_ptr   = 0;
    bit        m_done  = 1'b0;
    apb_req_t           e_req;
    apb_resp_t [N-1:0]  e_resp;
    logic      [N-1:0]  e_gnt;
    logic               e_to;

    // Requester and completer behaviour.
    int        pend  [N];
    apb_req_t  mreq  [N];
    bit        mdone [N];
    int        cw = 0;
    bit        cerr = 1'b0;
    int        force_wait = -1;
    int        force_err  = -1;

    function automatic int pick(input logic [N-1:0] ps, input int ptr, input int excl);
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (ptr + i) % N;
            if (ps[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic new_xfer(input int k);
        mreq[k].psel    = 1'b0;
        mreq[k].penable = 1'b0;
        mreq[k].pwrite  = 1'($urandom);
        mreq[k].paddr   = $urandom;
        mreq[k].pwdata  = $urandom;
        mreq[k].pstrb   = 4'($urandom);
    endtask

    task automatic new_cw();
        cw   = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 5));
        cerr = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 3) == 0);
    endtask

    task automatic model_expect();
        e_req  = '0;
        e_resp = '0;
        e_gnt  = '0;
        e_to   = 1'b0;
        m_done = 1'b0;
        if (m_owner >= 0) begin
            e_gnt         = N'(1) << m_owner;
            e_req         = req_i[m_owner];
            e_req.psel    = 1'b1;
            e_req.penable = !m_setup;
            if (!m_setup) begin
                e_resp[m_owner] = resp_i;
                if (resp_i.pready) begin
                    m_done = 1'b1;
                end else if (T != 0 && m_acc == T - 1) begin
                    m_done = 1'b1;
                    e_to   = 1'b1;
                    e_resp[m_owner].pready  = 1'b1;
                    e_resp[m_owner].prdata  = '0;
                    e_resp[m_owner].pslverr = 1'b1;
                end
                if (!req_i[m_owner].psel) e_resp[m_owner] = '0;
            end
        end
    endtask

    task automatic model_advance();
        logic [N-1:0] ps;
        int w;
        for (int k = 0; k < N; k++) ps[k] = req_i[k].psel;
        if (rst_i) begin
            m_owner = -1; m_setup = 1'b0; m_acc = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            w = pick(ps, m_ptr, -1);
            if (w >= 0) begin m_owner = w; m_setup = 1'b1; new_cw(); end
        end else if (m_setup) begin
            m_setup = 1'b0; m_acc = 0;
        end else if (m_done) begin
            m_ptr = (m_owner + 1) % N;
            w = pick(ps, m_ptr, m_owner);
            m_acc = 0;
            if (w >= 0) begin m_owner = w; m_setup = 1'b1; new_cw(); end
            else m_owner = -1;
        end else begin
            m_acc++;
        end
    endtask

    task automatic cyc_begin();
        for (int k = 0; k < N; k++) begin
            req_i[k]      = mreq[k];
            req_i[k].psel = (pend[k] > 0);
        end
        resp_i.prdata = $urandom;
        if (m_owner >= 0 && !m_setup) begin
            resp_i.pready  = (m_acc >= cw);
            resp_i.pslverr = (m_acc >= cw) && cerr;
        end else begin
            resp_i.pready  = 1'($urandom);
            resp_i.pslverr = 1'($urandom);
        end
        @(negedge clk_i);
        model_expect();
        if (!rst_i) begin
            check("req_o", 128'(req_o), 128'(e_req));
            check("gnt_o", 128'(gnt_o), 128'(e_gnt));
            check("resp_o", 128'(resp_o), 128'(e_resp));
            check("timeout_o", 128'(timeout_o), 128'(e_to));
        end
        for (int k = 0; k < N; k++) mdone[k] = !rst_i && e_resp[k].pready;
    endtask

    task automatic cyc_end();
        @(posedge clk_i);
        model_advance();
        #1;
        for (int k = 0; k < N; k++) begin
            if (mdone[k]) begin
                mdone[k] = 1'b0;
                if (pend[k] > 0) pend[k]--;
                new_xfer(k);
            end
        end
    endtask

    task automatic cyc();
        cyc_begin();
        cyc_end();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && m_owner < 0) break;
            cyc();
        end
    endtask

    logic [N-1:0] order[$];
    logic [N-1:0] t3_exp [4];
    int           acc_n;
    bit           seen;

    initial begin
        t3_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
        rst_i  = 1'b1;
        req_i  = '0;
        resp_i = '0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 0; mdone[k] = 1'b0; new_xfer(k);
        end
        repeat (2) cyc();
        rst_i = 1'b0;

        // Reset state
        cyc_begin();
        check("rst_gnt", 128'(gnt_o), 128'(0));
        check("rst_req", 128'(req_o), 128'(0));
        check("rst_resp", 128'(resp_o), 128'(0));
        check("rst_to", 128'(timeout_o), 128'(0));
        cyc_end();

        // 1: single write, zero-wait completer
        force_wait = 0; force_err = 0;
        mreq[0].pwrite = 1'b1; mreq[0].paddr = 32'h10; mreq[0].pwdata = 32'hDEADBEEF;
        pend[0] = 1;
        for (int c = 0; c < 5; c++) begin
            cyc_begin();
            case (c)
                0: check("t1_idle_gnt", 128'(gnt_o), 128'(0));
                1: begin
                    check("t1_setup_gnt", 128'(gnt_o), 128'(3'b001));
                    check("t1_setup_psel", 128'(req_o.psel), 128'(1));
                    check("t1_setup_pen", 128'(req_o.penable), 128'(0));
                    check("t1_paddr", 128'(req_o.paddr), 128'(32'h10));
                    check("t1_pwdata", 128'(req_o.pwdata), 128'(32'hDEADBEEF));
                end
                2: begin
                    check("t1_acc_pen", 128'(req_o.penable), 128'(1));
                    check("t1_acc_gnt", 128'(gnt_o), 128'(3'b001));
                    check("t1_pready", 128'(resp_o[0].pready), 128'(1));
                end
                3: check("t1_after_gnt", 128'(gnt_o), 128'(0));
                default: ;
            endcase
            cyc_end();
        end

        // 2: simultaneous requests after reset, back-to-back service
        rst_i = 1'b1; cyc(); rst_i = 1'b0;
        pend[0] = 1; pend[1] = 1;
        for (int c = 0; c < 6; c++) begin
            cyc_begin();
            case (c)
                1: check("t2_gnt0", 128'(gnt_o), 128'(3'b001));
                2: begin
                    check("t2_r1_stall", 128'(resp_o[1].pready), 128'(0));
                    check("t2_r0_ready", 128'(resp_o[0].pready), 128'(1));
                end
                3: begin
                    check("t2_gnt1", 128'(gnt_o), 128'(3'b010));
                    check("t2_b2b_setup", 128'(req_o.penable), 128'(0));
                end
                4: check("t2_r1_ready", 128'(resp_o[1].pready), 128'(1));
                5: check("t2_idle_gnt", 128'(gnt_o), 128'(0));
                default: ;
            endcase
            cyc_end();
        end

        // 3: fairness under sustained contention
        force_wait = -1; force_err = -1;
        pend[0] = 3; pend[1] = 4;
        order.delete();
        for (int c = 0; c < 150; c++) begin
            if (pend[0] == 0 && pend[1] == 0) break;
            cyc_begin();
            if (req_o.psel && !req_o.penable) order.push_back(gnt_o);
            cyc_end();
        end
        for (int i = 0; i < 4; i++) begin
            check("t3_order", 128'((i < order.size()) ? order[i] : 3'b111), 128'(t3_exp[i]));
        end
        drain(100);
        repeat (2) cyc();

        // 4: completer never ready -> forced error completion
        force_wait = 100; force_err = 0;
        pend[0] = 1;
        for (int c = 0; c < 7; c++) begin
            cyc_begin();
            case (c)
                1: check("t4_gnt", 128'(gnt_o), 128'(3'b001));
                4: check("t4_no_early_to", 128'(timeout_o), 128'(0));
                5: begin
                    check("t4_resp", 128'(resp_o[0]), 128'({1'b1, 32'h0, 1'b1}));
                    check("t4_to", 128'(timeout_o), 128'(1));
                end
                6: begin
                    check("t4_psel_drop", 128'(req_o.psel), 128'(0));
                    check("t4_to_pulse", 128'(timeout_o), 128'(0));
                end
                default: ;
            endcase
            cyc_end();
        end

        // 5: reset during a waited ACCESS
        force_wait = 2;
        pend[1] = 1;
        cyc(); cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        pend[1] = 0;
        cyc_begin();
        check("t5_req", 128'(req_o), 128'(0));
        check("t5_gnt", 128'(gnt_o), 128'(0));
        check("t5_resp", 128'(resp_o), 128'(0));
        cyc_end();
        force_wait = 0;
        pend[0] = 1; pend[1] = 1;
        cyc();
        cyc_begin();
        check("t5_ptr0", 128'(gnt_o), 128'(3'b001));
        cyc_end();
        drain(50);
        repeat (2) cyc();

        // 6: three wait states, error on the final beat
        force_wait = 3; force_err = 1;
        pend[0] = 1;
        acc_n = 0; seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cyc_begin();
            if (req_o.psel && req_o.penable) acc_n++;
            if (!seen && resp_o[0].pready) begin
                seen = 1'b1;
                check("t6_pslverr", 128'(resp_o[0].pslverr), 128'(1));
                check("t6_no_to", 128'(timeout_o), 128'(0));
                check("t6_beats", 128'(acc_n), 128'(4));
            end
            cyc_end();
        end
        check("t6_seen", 128'(seen), 128'(1));

        // Random traffic
        force_wait = -1; force_err = -1;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (pend[k] == 0 && $urandom_range(0, 3) == 0) pend[k] = int'($urandom_range(1, 3));
            end
            cyc();
        end
        drain(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
